// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Synchronizes a raw, possibly bouncing 1-bit input into the
//                clk domain and commits a new level only after STABLE_CYCLES
//                consecutive identical samples. Emits one-cycle rise/fall
//                strobes aligned with the first cycle of the new level.
//  Ports       : clk    - single clock, rising edge
//                rst    - synchronous active-high reset
//                in_raw - raw asynchronous input
//                out    - debounced level (registered)
//                rise   - one-cycle strobe on committed 0->1
//                fall   - one-cycle strobe on committed 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam logic [1:0] c_LOW      = 2'd0;
    localparam logic [1:0] c_CHK_HIGH = 2'd1;
    localparam logic [1:0] c_HIGH     = 2'd2;
    localparam logic [1:0] c_CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_out_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Two-flop synchronizer; only r_sync2 is seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= in_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LOW;
            r_cnt   <= c_CNT_ZERO;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // cnt holds the number of consecutive opposite samples seen so far in a
    // check state; the sample that would make it STABLE_CYCLES commits instead
    // of incrementing, so the counter never exceeds STABLE_CYCLES-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = c_CHK_HIGH;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end
            c_CHK_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = c_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = c_CHK_LOW;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end
            c_CHK_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = c_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_LOW;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never glitch.
    always_comb begin
        w_out_nxt  = (w_state_nxt == c_HIGH) || (w_state_nxt == c_CHK_LOW);
        w_rise_nxt = (r_state == c_CHK_HIGH) && (w_state_nxt == c_HIGH);
        w_fall_nxt = (r_state == c_CHK_LOW)  && (w_state_nxt == c_LOW);
    end

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Scoreboard bench for input_debouncer. A driver applies
//                directed and random in_raw/rst sequences and pushes the
//                expected {out,rise,fall} for each edge into a queue; a
//                monitor pops and compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int c_N = 4;

    logic clk;
    logic rst;
    logic in_raw;
    logic out;
    logic rise;
    logic fall;

    input_debouncer #(
        .STABLE_CYCLES(c_N),
        .CNT_W        (16)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .in_raw(in_raw),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw value delayed two edges, then a level that flips
    // only after c_N consecutive samples disagreeing with it.
    logic m_d1, m_d2, m_level;
    int   m_run;
    logic [2:0] exp_q[$];

    int vectors;
    int miscompares;
    bit drive_done;

    task automatic step(input logic r, input logic raw);
        logic s;
        logic e_rise, e_fall;
        @(negedge clk);
        rst    = r;
        in_raw = raw;
        e_rise = 1'b0;
        e_fall = 1'b0;
        if (r) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0;
        end else begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = raw;
            if (s != m_level) begin
                m_run++;
                if (m_run == c_N) begin
                    m_level = s;
                    m_run   = 0;
                    e_rise  = s;
                    e_fall  = ~s;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_level, e_rise, e_fall});
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(1'b0, raw);
    endtask

    // Monitor: one expected entry per rising edge once driving has started.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({out, rise, fall} !== e) begin
                    miscompares++;
                    $display("FAIL edge_check t=%0t actual out/rise/fall=%b%b%b required=%b%b%b",
                             $time, out, rise, fall, e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [0:8] bounce;
        vectors     = 0;
        miscompares = 0;
        drive_done  = 1'b0;
        rst         = 1'b1;
        in_raw      = 1'b0;
        m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_run = 0;

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b0, 4);
        // Clean rise, then clean fall
        hold(1'b1, 12);
        hold(1'b0, 12);
        // Short glitch (N-1 cycles) rejected
        hold(1'b1, c_N - 1);
        hold(1'b0, 10);
        // Exact-threshold pulse accepted
        hold(1'b1, c_N);
        hold(1'b0, 12);
        // Bouncing fall from committed high
        hold(1'b1, 10);
        bounce = 9'b010010000;
        for (int i = 0; i < 9; i++) step(1'b0, bounce[i]);
        hold(1'b0, 8);
        // Reset mid-check, input still high afterwards
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b1, 10);
        // Reset while high and mid-fall-check
        hold(1'b0, 3);
        step(1'b1, 1'b0);
        hold(1'b0, 6);
        // Bouncing rise
        bounce = 9'b101101111;
        for (int i = 0; i < 9; i++) step(1'b0, bounce[i]);
        hold(1'b1, 8);
        // Random runs around the threshold with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 29) == 0) step(1'b1, 1'($urandom_range(0, 1)));
            else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * c_N + 1)));
        end
        hold(1'b0, 10);
        drive_done = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain actual pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
